// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_t;

  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_START      = 3'd1,
    RX_DATA       = 3'd2,
    RX_PARITY     = 3'd3,
    RX_STOP       = 3'd4,
    RX_STOP2      = 3'd5,
    RX_BREAK_WAIT = 3'd6
  } rx_state_t;

  localparam int unsigned DATA_BITS_MIN = 5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every max(i_div,1) clocks.
module uart_baud_tick (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_div,
  output logic        o_tick
);

  logic [15:0] cnt_q;
  logic        tick_q;

  // Free-running down-counter; terminal count reloads and emits the tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == 16'd0) begin
      cnt_q  <= (i_div == 16'd0) ? 16'd0 : i_div - 16'd1;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q - 16'd1;
      tick_q <= 1'b0;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority voting, parity/frame checks,
// break detection and a valid/ready output word with overrun reporting.
//
// state         | meaning
// RX_IDLE       | line idle, waiting for a tick that samples low
// RX_START      | start bit, verified by majority vote at bit centre
// RX_DATA       | collecting the latched number of data bits
// RX_PARITY     | parity bit
// RX_STOP       | first stop bit (break decided here)
// RX_STOP2      | second stop bit when two stop bits are configured
// RX_BREAK_WAIT | break seen, waiting for the line to return high
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DATA_W_MAX  = 9,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [15:0]           i_baud_div,
  input  logic [3:0]            i_data_bits,
  input  parity_mode_t          i_parity_mode,
  input  logic                  i_two_stop,
  input  logic                  i_msb_first,
  input  logic                  i_rx,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic [DATA_W_MAX-1:0] o_rx_data,
  output logic                  o_parity_error,
  output logic                  o_frame_error,
  output logic                  o_break,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int TW = $clog2(OVS);
  localparam int IW = $clog2(DATA_W_MAX);
  localparam logic [TW-1:0] T_S0   = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVS/2);
  localparam logic [TW-1:0] T_S2   = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   tick;

  rx_state_t              state_q;
  logic [TW-1:0]          tcnt_q;
  logic [1:0]             smp_q;
  logic [3:0]             bidx_q;
  logic [3:0]             nbits_q;
  parity_mode_t           pmode_q;
  logic                   two_stop_q;
  logic                   msb_q;
  logic [DATA_W_MAX-1:0]  shreg_q;
  logic                   par_q;
  logic                   zero_q;
  logic                   perr_q;
  logic                   ferr_q;

  logic                   valid_q;
  logic [DATA_W_MAX-1:0]  data_q;
  logic                   perr_out_q;
  logic                   ferr_out_q;
  logic                   brk_q;
  logic                   ovr_q;

  logic                   vote;
  logic                   decide;
  logic [3:0]             nbits_c;
  logic [3:0]             pos4;
  logic [IW-1:0]          pos_c;
  logic                   perr_c;
  logic                   fin_c;
  logic                   fin_ferr_c;

  uart_baud_tick u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_div  (i_baud_div),
    .o_tick (tick)
  );

  // Resynchronise the asynchronous line; idle level is high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= i_rx;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Bit vote, config clamp, bit placement, parity check and frame-end detect.
  always_comb begin
    vote   = maj3(smp_q[0], smp_q[1], rx_s);
    decide = tick && (tcnt_q == T_S2);

    if (i_data_bits < 4'(DATA_BITS_MIN))    nbits_c = 4'(DATA_BITS_MIN);
    else if (i_data_bits > 4'(DATA_W_MAX))  nbits_c = 4'(DATA_W_MAX);
    else                                    nbits_c = i_data_bits;

    pos4  = msb_q ? (nbits_q - 4'd1 - bidx_q) : bidx_q;
    pos_c = IW'(pos4);

    case (pmode_q)
      PAR_EVEN:  perr_c = par_q ^ vote;
      PAR_ODD:   perr_c = ~(par_q ^ vote);
      PAR_MARK:  perr_c = ~vote;
      PAR_SPACE: perr_c = vote;
      default:   perr_c = 1'b0;
    endcase

    fin_c      = 1'b0;
    fin_ferr_c = ferr_q;
    if (decide && state_q == RX_STOP && !(zero_q && !vote) && !two_stop_q) begin
      fin_c      = 1'b1;
      fin_ferr_c = ~vote;
    end
    if (decide && state_q == RX_STOP2) begin
      fin_c      = 1'b1;
      fin_ferr_c = ferr_q | ~vote;
    end
  end

  // Receive FSM with registered word, flags and event pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= RX_IDLE;
      tcnt_q     <= '0;
      smp_q      <= '0;
      bidx_q     <= '0;
      nbits_q    <= '0;
      pmode_q    <= PAR_NONE;
      two_stop_q <= 1'b0;
      msb_q      <= 1'b0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      zero_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      brk_q <= 1'b0;
      ovr_q <= 1'b0;

      if (valid_q && i_rx_ready) valid_q <= 1'b0;

      // A held, unaccepted word wins over a newly completed one.
      if (fin_c) begin
        if (valid_q && !i_rx_ready) begin
          ovr_q <= 1'b1;
        end else begin
          valid_q    <= 1'b1;
          data_q     <= shreg_q;
          perr_out_q <= perr_q;
          ferr_out_q <= fin_ferr_c;
        end
      end

      if (tick) begin
        tcnt_q <= (tcnt_q == T_LAST) ? '0 : tcnt_q + TW'(1);
        if (tcnt_q == T_S0) smp_q[0] <= rx_s;
        if (tcnt_q == T_S1) smp_q[1] <= rx_s;

        case (state_q)
          RX_IDLE: begin
            tcnt_q <= '0;
            if (!rx_s) begin
              state_q    <= RX_START;
              tcnt_q     <= TW'(1);
              nbits_q    <= nbits_c;
              pmode_q    <= i_parity_mode;
              two_stop_q <= i_two_stop;
              msb_q      <= i_msb_first;
              shreg_q    <= '0;
              bidx_q     <= '0;
              par_q      <= 1'b0;
              zero_q     <= 1'b1;
              perr_q     <= 1'b0;
              ferr_q     <= 1'b0;
            end
          end
          RX_START: begin
            if (tcnt_q == T_S2) state_q <= vote ? RX_IDLE : RX_DATA;
          end
          RX_DATA: begin
            if (tcnt_q == T_S2) begin
              shreg_q[pos_c] <= vote;
              par_q          <= par_q ^ vote;
              zero_q         <= zero_q & ~vote;
              if (bidx_q == nbits_q - 4'd1) begin
                bidx_q  <= '0;
                state_q <= (pmode_q == PAR_NONE) ? RX_STOP : RX_PARITY;
              end else begin
                bidx_q <= bidx_q + 4'd1;
              end
            end
          end
          RX_PARITY: begin
            if (tcnt_q == T_S2) begin
              perr_q  <= perr_c;
              zero_q  <= zero_q & ~vote;
              state_q <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (tcnt_q == T_S2) begin
              if (zero_q && !vote) begin
                brk_q   <= 1'b1;
                state_q <= RX_BREAK_WAIT;
              end else if (two_stop_q) begin
                ferr_q  <= ~vote;
                state_q <= RX_STOP2;
              end else begin
                state_q <= RX_IDLE;
              end
            end
          end
          RX_STOP2: begin
            if (tcnt_q == T_S2) state_q <= RX_IDLE;
          end
          RX_BREAK_WAIT: begin
            tcnt_q <= '0;
            if (rx_s) state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign o_rx_valid     = valid_q;
  assign o_rx_data      = data_q;
  assign o_parity_error = perr_out_q;
  assign o_frame_error  = ferr_out_q;
  assign o_break        = brk_q;
  assign o_overrun      = ovr_q;
  assign o_busy         = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Testbench for uart_rx_ovs: OVS=16, baud divider 4, 64 clocks per bit.
module tb_uart_rx_ovs;
  import uart_pkg::*;

  localparam int DW      = 9;
  localparam int BIT_CLK = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  baud_div = 16'd4;
  logic [3:0]   data_bits = 4'd8;
  parity_mode_t pmode = PAR_NONE;
  logic         two_stop = 1'b0;
  logic         msb_first = 1'b0;
  logic         rx = 1'b1;
  logic         rx_ready = 1'b0;

  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          perr, ferr, brk, ovr, busy;

  always #5 clk = ~clk;

  uart_rx_ovs #(.DATA_W_MAX(DW), .OVS(16), .SYNC_STAGES(2)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_baud_div     (baud_div),
    .i_data_bits    (data_bits),
    .i_parity_mode  (pmode),
    .i_two_stop     (two_stop),
    .i_msb_first    (msb_first),
    .i_rx           (rx),
    .o_rx_valid     (rx_valid),
    .i_rx_ready     (rx_ready),
    .o_rx_data      (rx_data),
    .o_parity_error (perr),
    .o_frame_error  (ferr),
    .o_break        (brk),
    .o_overrun      (ovr),
    .o_busy         (busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } item_t;

  item_t exp_q[$];
  item_t got_q[$];
  int    vec = 0;
  int    err = 0;
  int    brk_cnt = 0;
  int    ovr_cnt = 0;
  int    vrise = 0;
  logic  valid_d = 1'b0;

  // Monitor: records accepted words and counts event pulses.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back({rx_data, perr, ferr});
    if (brk === 1'b1) brk_cnt++;
    if (ovr === 1'b1) ovr_cnt++;
    if (rx_valid === 1'b1 && valid_d !== 1'b1) vrise++;
    valid_d = rx_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cyc(BIT_CLK);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input logic msb,
                            input parity_mode_t pm, input logic bad_par,
                            input logic stop_v, input logic two, input int idle_bits);
    logic p;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(msb ? d[nb-1-i] : d[i]);
    p = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    case (pm)
      PAR_ODD:   p = ~p;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = p;
    endcase
    if (pm != PAR_NONE) drive_bit(p ^ bad_par);
    drive_bit(stop_v);
    if (two) drive_bit(1'b1);
    rx = 1'b1;
    if (idle_bits > 0) cyc(idle_bits * BIT_CLK);
  endtask

  task automatic accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * BIT_CLK; i++) begin
      if (rx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    if (ok) begin
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
      cyc(1);
    end
  endtask

  task automatic pop_pair(output item_t g, output item_t e, output bit ok);
    g  = '0;
    e  = '0;
    ok = (got_q.size() > 0) && (exp_q.size() > 0);
    if (ok) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
    end
  endtask

  task automatic set_cfg(input logic [3:0] nb, input parity_mode_t pm, input logic two, input logic msb);
    data_bits = nb;
    pmode     = pm;
    two_stop  = two;
    msb_first = msb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    vec++; if (rx_valid !== 1'b0) begin err++; $display("FAIL rst_valid: got %b exp 0", rx_valid); end
    vec++; if (rx_data !== '0) begin err++; $display("FAIL rst_data: got %h exp 000", rx_data); end
    vec++; if (perr !== 1'b0) begin err++; $display("FAIL rst_perr: got %b exp 0", perr); end
    vec++; if (ferr !== 1'b0) begin err++; $display("FAIL rst_ferr: got %b exp 0", ferr); end
    vec++; if (brk !== 1'b0) begin err++; $display("FAIL rst_break: got %b exp 0", brk); end
    vec++; if (ovr !== 1'b0) begin err++; $display("FAIL rst_overrun: got %b exp 0", ovr); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    rst = 1'b0;
    cyc(8);
  endtask

  task automatic test_basic();
    item_t g, e;
    bit    ok;
    set_cfg(4'd8, PAR_NONE, 1'b0, 1'b0);
    exp_q.push_back({9'h0A5, 1'b0, 1'b0});
    send_frame(9'h0A5, 8, 1'b0, PAR_NONE, 1'b0, 1'b1, 1'b0, 1);
    vec++; if (rx_valid !== 1'b1) begin err++; $display("FAIL a5_valid_held: got %b exp 1", rx_valid); end
    cyc(20);
    vec++; if (rx_valid !== 1'b1 || rx_data !== 9'h0A5) begin err++; $display("FAIL a5_stable: got valid %b data %h exp 1 0a5", rx_valid, rx_data); end
    accept(ok);
    vec++; if (!ok) begin err++; $display("FAIL a5_wait: got timeout exp valid"); end
    vec++; if (rx_valid !== 1'b0) begin err++; $display("FAIL a5_valid_drop: got %b exp 0", rx_valid); end
    pop_pair(g, e, ok);
    vec++; if (!ok || g.data !== e.data) begin err++; $display("FAIL a5_data: got %h exp %h", g.data, e.data); end
    vec++; if (!ok || g.perr !== e.perr || g.ferr !== e.ferr) begin err++; $display("FAIL a5_flags: got %b%b exp %b%b", g.perr, g.ferr, e.perr, e.ferr); end
  endtask

  task automatic test_parity();
    item_t g, e;
    bit    ok;
    set_cfg(4'd8, PAR_EVEN, 1'b0, 1'b0);
    exp_q.push_back({9'h03C, 1'b1, 1'b0});
    send_frame(9'h03C, 8, 1'b0, PAR_EVEN, 1'b1, 1'b1, 1'b0, 1);
    accept(ok);
    pop_pair(g, e, ok);
    vec++; if (!ok || g.data !== e.data) begin err++; $display("FAIL par_data: got %h exp %h", g.data, e.data); end
    vec++; if (!ok || g.perr !== e.perr) begin err++; $display("FAIL par_perr: got %b exp %b", g.perr, e.perr); end
    vec++; if (!ok || g.ferr !== e.ferr) begin err++; $display("FAIL par_ferr: got %b exp %b", g.ferr, e.ferr); end
  endtask

  task automatic test_msb_first();
    item_t g, e;
    bit    ok;
    set_cfg(4'd7, PAR_NONE, 1'b0, 1'b1);
    exp_q.push_back({9'h055, 1'b0, 1'b0});
    send_frame(9'h055, 7, 1'b1, PAR_NONE, 1'b0, 1'b1, 1'b0, 1);
    accept(ok);
    pop_pair(g, e, ok);
    vec++; if (!ok || g.data !== e.data) begin err++; $display("FAIL msb55_data: got %h exp %h", g.data, e.data); end
    // Config changes mid-frame must not affect the frame in flight.
    set_cfg(4'd8, PAR_NONE, 1'b0, 1'b1);
    exp_q.push_back({9'h01E, 1'b0, 1'b0});
    fork
      send_frame(9'h01E, 8, 1'b1, PAR_NONE, 1'b0, 1'b1, 1'b0, 1);
      begin
        cyc(3 * BIT_CLK);
        set_cfg(4'd5, PAR_EVEN, 1'b1, 1'b0);
      end
    join
    accept(ok);
    pop_pair(g, e, ok);
    vec++; if (!ok || g.data !== e.data || g.perr !== 1'b0 || g.ferr !== 1'b0) begin err++; $display("FAIL msb1e_latched: got %h %b%b exp %h 00", g.data, g.perr, g.ferr, e.data); end
  endtask

  task automatic test_clamp();
    item_t g, e;
    bit    ok;
    set_cfg(4'd3, PAR_NONE, 1'b0, 1'b0);
    exp_q.push_back({9'h015, 1'b0, 1'b0});
    send_frame(9'h015, 5, 1'b0, PAR_NONE, 1'b0, 1'b1, 1'b0, 1);
    accept(ok);
    pop_pair(g, e, ok);
    vec++; if (!ok || g.data !== e.data) begin err++; $display("FAIL clamp_lo: got %h exp %h", g.data, e.data); end
    set_cfg(4'd15, PAR_NONE, 1'b0, 1'b0);
    exp_q.push_back({9'h1A5, 1'b0, 1'b0});
    send_frame(9'h1A5, 9, 1'b0, PAR_NONE, 1'b0, 1'b1, 1'b0, 1);
    accept(ok);
    pop_pair(g, e, ok);
    vec++; if (!ok || g.data !== e.data) begin err++; $display("FAIL clamp_hi: got %h exp %h", g.data, e.data); end
  endtask

  task automatic test_glitch();
    int v0;
    set_cfg(4'd8, PAR_NONE, 1'b0, 1'b0);
    v0 = vrise;
    rx = 1'b0;
    cyc(8);
    rx = 1'b1;
    cyc(4);
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL glitch_busy_hi: got %b exp 1", busy); end
    cyc(BIT_CLK);
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL glitch_busy_lo: got %b exp 0", busy); end
    vec++; if (vrise != v0 || got_q.size() != 0) begin err++; $display("FAIL glitch_novalid: got %0d words exp 0", vrise - v0); end
  endtask

  task automatic test_frame_error();
    item_t g, e;
    bit    ok;
    set_cfg(4'd8, PAR_NONE, 1'b0, 1'b0);
    exp_q.push_back({9'h03C, 1'b0, 1'b1});
    send_frame(9'h03C, 8, 1'b0, PAR_NONE, 1'b0, 1'b0, 1'b0, 2);
    accept(ok);
    pop_pair(g, e, ok);
    vec++; if (!ok || g.data !== e.data) begin err++; $display("FAIL ferr_data: got %h exp %h", g.data, e.data); end
    vec++; if (!ok || g.ferr !== e.ferr || g.perr !== e.perr) begin err++; $display("FAIL ferr_flag: got %b%b exp %b%b", g.perr, g.ferr, e.perr, e.ferr); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL ferr_idle: got busy %b exp 0", busy); end
  endtask

  task automatic test_break();
    int v0, b0;
    set_cfg(4'd8, PAR_NONE, 1'b0, 1'b0);
    v0 = vrise;
    b0 = brk_cnt;
    rx = 1'b0;
    cyc(12 * BIT_CLK);
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL brk_wait_busy: got %b exp 1", busy); end
    rx = 1'b1;
    cyc(2 * BIT_CLK);
    vec++; if (brk_cnt - b0 != 1) begin err++; $display("FAIL brk_pulses: got %0d exp 1", brk_cnt - b0); end
    vec++; if (vrise != v0) begin err++; $display("FAIL brk_novalid: got %0d exp 0", vrise - v0); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL brk_idle: got %b exp 0", busy); end
  endtask

  task automatic test_overrun();
    item_t g, e;
    bit    ok;
    int    o0;
    set_cfg(4'd8, PAR_NONE, 1'b0, 1'b0);
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back({9'h011, 1'b0, 1'b0});
    send_frame(9'h011, 8, 1'b0, PAR_NONE, 1'b0, 1'b1, 1'b0, 0);
    send_frame(9'h022, 8, 1'b0, PAR_NONE, 1'b0, 1'b1, 1'b0, 1);
    vec++; if (rx_valid !== 1'b1 || rx_data !== 9'h011) begin err++; $display("FAIL ovr_held: got valid %b data %h exp 1 011", rx_valid, rx_data); end
    vec++; if (ovr_cnt - o0 != 1) begin err++; $display("FAIL ovr_pulses: got %0d exp 1", ovr_cnt - o0); end
    accept(ok);
    pop_pair(g, e, ok);
    vec++; if (!ok || g.data !== e.data) begin err++; $display("FAIL ovr_data: got %h exp %h", g.data, e.data); end
    cyc(4);
    vec++; if (got_q.size() != 0 || rx_valid !== 1'b0) begin err++; $display("FAIL ovr_discard: got %0d extra words valid %b exp 0 0", got_q.size(), rx_valid); end
  endtask

  task automatic test_reset_mid();
    item_t      g, e;
    bit         ok;
    int         v0;
    logic [8:0] d;
    d = 9'h07E;
    set_cfg(4'd8, PAR_NONE, 1'b0, 1'b0);
    v0 = vrise;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    cyc(BIT_CLK / 2);
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL rstmid_busy_pre: got %b exp 1", busy); end
    rst = 1'b1;
    cyc(1);
    vec++; if ({rx_valid, rx_data, perr, ferr, brk, ovr, busy} !== '0) begin err++; $display("FAIL rstmid_outputs: got v%b d%h p%b f%b b%b o%b y%b exp all 0", rx_valid, rx_data, perr, ferr, brk, ovr, busy); end
    rst = 1'b0;
    rx  = 1'b1;
    cyc(2 * BIT_CLK);
    vec++; if (vrise != v0 || got_q.size() != 0) begin err++; $display("FAIL rstmid_partial: got %0d words exp 0", vrise - v0); end
    exp_q.push_back({9'h07E, 1'b0, 1'b0});
    send_frame(9'h07E, 8, 1'b0, PAR_NONE, 1'b0, 1'b1, 1'b0, 1);
    accept(ok);
    pop_pair(g, e, ok);
    vec++; if (!ok || g != e) begin err++; $display("FAIL rstmid_7e: got %h %b%b exp %h %b%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr); end
  endtask

  task automatic test_back_to_back();
    item_t g, e;
    bit    ok;
    int    o0;
    set_cfg(4'd8, PAR_ODD, 1'b1, 1'b0);
    o0 = ovr_cnt;
    rx_ready = 1'b1;
    exp_q.push_back({9'h05A, 1'b0, 1'b0});
    exp_q.push_back({9'h0C3, 1'b0, 1'b0});
    send_frame(9'h05A, 8, 1'b0, PAR_ODD, 1'b0, 1'b1, 1'b1, 0);
    send_frame(9'h0C3, 8, 1'b0, PAR_ODD, 1'b0, 1'b1, 1'b1, 1);
    rx_ready = 1'b0;
    cyc(2);
    pop_pair(g, e, ok);
    vec++; if (!ok || g != e) begin err++; $display("FAIL b2b_first: got %h %b%b exp %h %b%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr); end
    pop_pair(g, e, ok);
    vec++; if (!ok || g != e) begin err++; $display("FAIL b2b_second: got %h %b%b exp %h %b%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr); end
    vec++; if (ovr_cnt != o0) begin err++; $display("FAIL b2b_no_overrun: got %0d exp 0", ovr_cnt - o0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_msb_first();
    test_clamp();
    test_glitch();
    test_frame_error();
    test_break();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter DATA_W_MAX, default 9, max data bits per frame (5..9).
REQ-002 SHALL have parameter OVS, default 16, oversample ticks per bit (even, 8..32).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, i_rx synchroniser depth.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have i_clk  in  1  clock.
REQ-006 SHALL have i_rst  in  1  synchronous active-high reset.
REQ-007 SHALL have i_baud_div  in  16  clocks per oversample tick; 0 treated as 1.
REQ-008 SHALL have i_data_bits  in  4  data bits per frame; clamped to 5..DATA_W_MAX.
REQ-009 SHALL have i_parity_mode  in  parity_mode_t  NONE/EVEN/ODD/MARK/SPACE.
REQ-010 SHALL have i_two_stop  in  1  1 = two stop bits checked.
REQ-011 SHALL have i_msb_first  in  1  bit order on the line.
REQ-012 SHALL have i_rx  in  1  asynchronous serial line, idle high.
REQ-013 SHALL have o_rx_valid, i_rx_ready, o_rx_data  out/in/out  1/1/DATA_W_MAX  receive word handshake.
REQ-014 SHALL have o_parity_error, o_frame_error  out  1  qualifiers valid with o_rx_valid.
REQ-015 SHALL have o_break, o_overrun  out  1  one-cycle event pulses.
REQ-016 SHALL have o_busy  out  1  high when the state is not IDLE.

Function
REQ-017 SHALL pass i_rx through SYNC_STAGES flops reset to 1; all logic uses the synchronised value.
REQ-018 SHALL generate a tick every max(i_baud_div,1) clocks from a free-running counter.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP, STOP2, BREAK_WAIT.
REQ-020 IDLE->START on the first tick sampling line low; latch i_data_bits, i_parity_mode, i_two_stop, i_msb_first there; mid-frame config changes have no effect.
REQ-021 Each bit SHALL be decided by 2-of-3 majority of samples at ticks OVS/2-1, OVS/2, OVS/2+1 of the bit.
REQ-022 START voting 1 (false start) SHALL return to IDLE with no output.
REQ-023 DATA SHALL collect the latched bit count, then go to PARITY if mode != NONE, else STOP; STOP->STOP2 if two stop bits, else frame end.
REQ-024 Word SHALL be LSB-aligned in o_rx_data, reordered per i_msb_first, unused upper bits 0.
REQ-025 Parity error: EVEN/ODD mismatch on XOR of data+parity bit; MARK expects 1; SPACE expects 0.
REQ-026 Frame error: any checked stop bit voted 0.
REQ-027 Break: all data bits, parity (if any) and first stop bit 0 -> o_break pulse, no word delivered, go to BREAK_WAIT until line high for one full tick, then IDLE.
REQ-028 Frame end: word and flags registered; o_rx_valid rises the clock after the last stop-bit vote; holds data stable until i_rx_ready.
REQ-029 Frame completing while o_rx_valid=1 and i_rx_ready=0: new word discarded, held word kept, o_overrun pulsed.
REQ-030 Completion coinciding with a valid&ready transfer: not overrun; the new word is loaded and o_rx_valid stays 1.
REQ-031 Receiver SHALL return to IDLE at the centre of the last stop bit, ready for back-to-back frames.

Reset
REQ-032 i_rst SHALL force state IDLE, sync flops 1, counters 0, o_rx_data 0, all outputs 0, mid-frame included; no partial word is delivered.

Structure
REQ-033 parity_mode_t and the rx state enum SHALL be added to uart_pkg.
REQ-034 Tick generation SHALL be a sub-module uart_baud_tick (i_clk, i_rst, i_div, o_tick).

Verification (OVS=16, i_baud_div=4, 64 clk/bit)
REQ-035 0xA5, 8N1, LSB first -> o_rx_data=0x0A5, o_rx_valid until ready, no error flags.
REQ-036 0x3C, 8E1 with parity bit 1 -> o_rx_data=0x03C, o_parity_error=1; 7-bit MSB-first 0x55 -> 0x055.
REQ-037 Low glitch of 2 ticks, then line high -> no o_rx_valid, o_busy back to 0 within 1 bit time.
REQ-038 0x3C with stop bit 0 -> o_frame_error=1; line low 12 bit times -> single o_break pulse, no valid.
REQ-039 Two frames 0x11, 0x22 with i_rx_ready=0 -> o_rx_data stays 0x011, one o_overrun pulse.
REQ-040 i_rst at data bit 4 -> all outputs 0 next cycle; following clean frame 0x7E received correctly.
